// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM states, owner codes, access-size codes and starvation-counter sizing for mem_arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        MA_IDLE    = 2'b00,
        MA_BUSY_IF = 2'b01,
        MA_BUSY_D  = 2'b10,
        MA_RESP    = 2'b11
    } ma_state_t;
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;
    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    function automatic int starve_w(input int max_burst);
        return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
    endfunction
endpackage

// File: rtl/mem_arb_prio_sel.sv
// mem_arb_prio_sel: combinational grant decision between fetch and data requesters
// Ports: i_if_req, i_d_req (pending requests), i_starve_cnt (data grants since fetch last won),
//        o_grant_if, o_grant_d (one-hot or none)
module mem_arb_prio_sel
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4,
    parameter int SW             = starve_w(MAX_DATA_BURST)
) (
    input  logic          i_if_req,
    input  logic          i_d_req,
    input  logic [SW-1:0] i_starve_cnt,
    output logic          o_grant_if,
    output logic          o_grant_d
);
    localparam logic [SW-1:0] MAX_C = SW'(MAX_DATA_BURST);
    // Data wins unless fetch is waiting and has already been passed over MAX_DATA_BURST times
    assign o_grant_d  = i_d_req & ((MAX_DATA_BURST == 0) | !i_if_req | (i_starve_cnt < MAX_C));
    assign o_grant_if = i_if_req & !o_grant_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between fetch and load/store ports
// Ports: clk, rst (async, active-low); if_* fetch port; d_* data port; m_* memory port;
//        stall (pending unacked request), owner (00 none, 01 fetch, 10 data), perf_* counters.
// Optional: define MEM_ARB_PERF_EN to build the performance counters; otherwise they read 0.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              stall,
    output logic [1:0]        owner,
    output logic [31:0]       perf_if_cnt,
    output logic [31:0]       perf_d_cnt,
    output logic [31:0]       perf_stall_cnt
);
    localparam int            SW    = starve_w(MAX_DATA_BURST);
    localparam logic [SW-1:0] MAX_C = SW'(MAX_DATA_BURST);

    ma_state_t     r_state;
    logic [SW-1:0] r_starve;
    logic          w_grant_if;
    logic          w_grant_d;

    mem_arb_prio_sel #(
        .MAX_DATA_BURST(MAX_DATA_BURST),
        .SW            (SW)
    ) u_prio_sel (
        .i_if_req    (if_req),
        .i_d_req     (d_req),
        .i_starve_cnt(r_starve),
        .o_grant_if  (w_grant_if),
        .o_grant_d   (w_grant_d)
    );

    assign stall = (if_req & !if_ack) | (d_req & !d_ack);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= MA_IDLE;
            r_starve <= '0;
            owner    <= OWN_NONE;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_size   <= '0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (r_state)
                MA_IDLE: begin
                    if (w_grant_d) begin
                        r_state  <= MA_BUSY_D;
                        owner    <= OWN_D;
                        m_req    <= 1'b1;
                        m_we     <= d_we;
                        m_size   <= d_size;
                        m_addr   <= d_addr;
                        m_wdata  <= d_wdata;
                        // Starvation only accrues while fetch is actually waiting; saturates at the limit
                        r_starve <= !if_req ? '0 : (r_starve == MAX_C) ? r_starve : r_starve + SW'(1);
                    end else if (w_grant_if) begin
                        r_state  <= MA_BUSY_IF;
                        owner    <= OWN_IF;
                        m_req    <= 1'b1;
                        m_we     <= 1'b0;
                        m_size   <= SIZE_W;
                        m_addr   <= if_addr;
                        r_starve <= '0;
                    end
                end
                MA_BUSY_IF, MA_BUSY_D: begin
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        r_state <= MA_RESP;
                        if (r_state == MA_BUSY_IF) begin
                            if_rdata <= m_rdata;
                            if_ack   <= 1'b1;
                        end else begin
                            d_rdata <= m_rdata;
                            d_ack   <= 1'b1;
                        end
                    end
                end
                MA_RESP: begin
                    r_state <= MA_IDLE;
                    owner   <= OWN_NONE;
                end
                default: r_state <= MA_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_cnt    <= '0;
            perf_d_cnt     <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (r_state == MA_RESP && owner == OWN_IF) perf_if_cnt <= perf_if_cnt + 32'd1;
            if (r_state == MA_RESP && owner == OWN_D) perf_d_cnt <= perf_d_cnt + 32'd1;
            if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    assign perf_if_cnt    = '0;
    assign perf_d_cnt     = '0;
    assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (burst 4 and strict-data instances)
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] mem_data = '0;
    logic        force_ack = 1'b0;
    int          lat = 1;
    int          n_cmp = 0;
    int          n_fail = 0;

    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata, perf_if, perf_d, perf_st;
    logic        if_ack, d_ack, m_req, m_we, stall, r_ack;
    logic [1:0]  m_size, owner;
    int          r_cnt;
    logic [31:0] z_if_rdata, z_d_rdata, z_m_addr, z_m_wdata, z_perf_if, z_perf_d, z_perf_st;
    logic        z_if_ack, z_d_ack, z_m_req, z_m_we, z_stall, z_r_ack;
    logic [1:0]  z_m_size, z_owner;
    int          z_r_cnt;

    logic [1:0]  grants[$];
    logic [1:0]  z_grants[$];
    logic        prev_req, z_prev_req;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(mem_data), .m_ack(r_ack | force_ack),
        .stall(stall), .owner(owner),
        .perf_if_cnt(perf_if), .perf_d_cnt(perf_d), .perf_stall_cnt(perf_st)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(z_if_rdata), .if_ack(z_if_ack),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(z_d_rdata), .d_ack(z_d_ack),
        .m_req(z_m_req), .m_we(z_m_we), .m_size(z_m_size), .m_addr(z_m_addr), .m_wdata(z_m_wdata),
        .m_rdata(mem_data), .m_ack(z_r_ack),
        .stall(z_stall), .owner(z_owner),
        .perf_if_cnt(z_perf_if), .perf_d_cnt(z_perf_d), .perf_stall_cnt(z_perf_st)
    );

    // Memory models: ack arrives lat cycles after m_req is first seen
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 0;
            r_ack <= 1'b0;
        end else if (m_req && !r_ack) begin
            if (r_cnt + 1 >= lat) begin
                r_ack <= 1'b1;
                r_cnt <= 0;
            end else r_cnt <= r_cnt + 1;
        end else begin
            r_ack <= 1'b0;
            r_cnt <= 0;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_r_cnt <= 0;
            z_r_ack <= 1'b0;
        end else if (z_m_req && !z_r_ack) begin
            if (z_r_cnt + 1 >= lat) begin
                z_r_ack <= 1'b1;
                z_r_cnt <= 0;
            end else z_r_cnt <= z_r_cnt + 1;
        end else begin
            z_r_ack <= 1'b0;
            z_r_cnt <= 0;
        end
    end

    // Record the owner at each rising m_req to recover grant order
    always @(negedge clk) begin
        if (!rst) begin
            prev_req = 1'b0;
            z_prev_req = 1'b0;
        end else begin
            if (m_req && !prev_req) grants.push_back(owner);
            if (z_m_req && !z_prev_req) z_grants.push_back(z_owner);
            prev_req = m_req;
            z_prev_req = z_m_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b0;
        if_req = 1'b0;
        d_req = 1'b0;
        force_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_xfer(input bit is_d);
        int k;
        @(negedge clk);
        if (is_d) d_req = 1'b1;
        else if_req = 1'b1;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (is_d ? d_ack : if_ack) break;
        end
        n_cmp++;
        if (k > 20) begin
            n_fail++;
            $display("FAIL xfer_timeout: got no ack want ack within 20 cycles (is_d=%0b)", is_d);
        end
        if_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({m_req, if_ack, d_ack, owner, stall} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got req=%0b ifa=%0b da=%0b own=%0b st=%0b want all 0",
                     m_req, if_ack, d_ack, owner, stall);
        end
        n_cmp++;
        if ({if_rdata, d_rdata, m_addr, m_wdata} !== 128'b0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h want 0", if_rdata, d_rdata, m_addr, m_wdata);
        end
        n_cmp++;
        if ({perf_if, perf_d, perf_st} !== 96'b0) begin
            n_fail++;
            $display("FAIL reset_perf: got %0d %0d %0d want 0", perf_if, perf_d, perf_st);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lone_fetch();
        int k;
        lat = 1;
        mem_data = 32'h0050_0093;
        if_addr = 32'h100;
        if_req = 1'b1;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_cmp++;
                if ({m_req, m_we, m_size, m_addr, owner} !== {1'b1, 1'b0, 2'b10, 32'h100, 2'b01}) begin
                    n_fail++;
                    $display("FAIL fetch_mfields: got req=%0b we=%0b sz=%0b addr=%h own=%0b want 1 0 10 100 01",
                             m_req, m_we, m_size, m_addr, owner);
                end
            end
            if (if_ack) break;
        end
        n_cmp++;
        if (k !== 3) begin
            n_fail++;
            $display("FAIL fetch_latency: got ack at cycle %0d want 3", k);
        end
        n_cmp++;
        if (if_rdata !== 32'h0050_0093 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_rdata: got %h stall=%0b want 00500093 stall=0", if_rdata, stall);
        end
        if_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({if_ack, owner, m_req} !== 4'b0) begin
            n_fail++;
            $display("FAIL fetch_single_ack: got ack=%0b own=%0b req=%0b want 0", if_ack, owner, m_req);
        end
    endtask

    task automatic test_store();
        int k;
        lat = 3;
        d_we = 1'b1;
        d_size = 2'b10;
        d_addr = 32'h2000;
        d_wdata = 32'hDEAD_BEEF;
        d_req = 1'b1;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (d_ack) break;
            n_cmp++;
            if (stall !== 1'b1) begin
                n_fail++;
                $display("FAIL store_stall: got %0b want 1 at cycle %0d", stall, k);
            end
            if (k <= 4) begin
                n_cmp++;
                if ({m_req, m_we, m_size, m_addr, m_wdata} !== {1'b1, 1'b1, 2'b10, 32'h2000, 32'hDEAD_BEEF}) begin
                    n_fail++;
                    $display("FAIL store_mfields: got req=%0b we=%0b sz=%0b addr=%h wd=%h want 1 1 10 2000 deadbeef",
                             m_req, m_we, m_size, m_addr, m_wdata);
                end
            end
            // Requester changes its address mid-transaction; memory side must not follow
            if (k == 1) begin
                d_addr = 32'h3000;
                d_wdata = 32'h1234_5678;
            end
        end
        n_cmp++;
        if (k !== 5 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL store_ack: got cycle %0d stall=%0b want 5 stall=0", k, stall);
        end
        d_req = 1'b0;
        d_we = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (d_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL store_single_ack: got %0b want 0", d_ack);
        end
        lat = 1;
    endtask

    task automatic test_spurious_ack();
        logic bad;
        bad = 1'b0;
        mem_data = 32'h0000_0BAD;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if ({m_req, if_ack, d_ack, owner} !== 5'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_ctrl: got activity=%0b want 0", bad);
        end
        n_cmp++;
        if (if_rdata !== 32'h0050_0093) begin
            n_fail++;
            $display("FAIL spurious_rdata: got %h want 00500093", if_rdata);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_order [10];
        exp_order = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        lat = 1;
        grants.delete();
        z_grants.delete();
        if_req = 1'b1;
        d_req = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (grants.size() >= 10 && z_grants.size() >= 10) break;
        end
        n_cmp++;
        if (grants.size() < 10 || z_grants.size() < 10) begin
            n_fail++;
            $display("FAIL contention_count: got %0d/%0d grants want >=10", grants.size(), z_grants.size());
        end
        for (int i = 0; i < 10 && i < grants.size(); i++) begin
            n_cmp++;
            if (grants[i] !== exp_order[i]) begin
                n_fail++;
                $display("FAIL burst4_order[%0d]: got %0b want %0b", i, grants[i], exp_order[i]);
            end
        end
        for (int i = 0; i < 10 && i < z_grants.size(); i++) begin
            n_cmp++;
            if (z_grants[i] !== 2'b10) begin
                n_fail++;
                $display("FAIL strict_order[%0d]: got %0b want 10", i, z_grants[i]);
            end
        end
        if_req = 1'b0;
        d_req = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic bad;
        bad = 1'b0;
        lat = 20;
        d_addr = 32'h40;
        d_req = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (m_req !== 1'b1 || owner !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_pre: got req=%0b own=%0b want 1 10", m_req, owner);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({m_req, d_ack, if_ack, owner} !== 5'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got req=%0b da=%0b ia=%0b own=%0b want 0", m_req, d_ack, if_ack, owner);
        end
        d_req = 1'b0;
        lat = 1;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if ({m_req, d_ack, if_ack, owner} !== 5'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_stray: got activity=%0b want 0", bad);
        end
    endtask

    task automatic test_perf();
        logic [31:0] exp_if, exp_d, exp_st;
`ifdef MEM_ARB_PERF_EN
        exp_if = 32'd5;
        exp_d = 32'd3;
        exp_st = 32'd24;
`else
        exp_if = 32'd0;
        exp_d = 32'd0;
        exp_st = 32'd0;
`endif
        do_reset();
        lat = 1;
        repeat (5) do_xfer(1'b0);
        repeat (3) do_xfer(1'b1);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (perf_if !== exp_if) begin
            n_fail++;
            $display("FAIL perf_if: got %0d want %0d", perf_if, exp_if);
        end
        n_cmp++;
        if (perf_d !== exp_d) begin
            n_fail++;
            $display("FAIL perf_d: got %0d want %0d", perf_d, exp_d);
        end
        n_cmp++;
        if (perf_st !== exp_st) begin
            n_fail++;
            $display("FAIL perf_stall: got %0d want %0d", perf_st, exp_st);
        end
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_store();
        test_spurious_ack();
        test_contention();
        test_reset_mid();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
